// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

    state_t           state, state_nx;
    logic [WIDTH:0]   p, p_sh, trial, p_nx;
    logic [WIDTH-1:0] dq, dvs, dq_nx;
    logic [CW-1:0]    cnt;
    logic             qbit, last;

    assign BUSY = state != IDLE;

    // one restoring step: shift in the next dividend bit, trial-subtract, keep or restore
    always_comb begin
        p_sh  = {p[WIDTH-1:0], dq[WIDTH-1]};
        trial = p_sh - {1'b0, dvs};
        qbit  = ~trial[WIDTH];
        p_nx  = qbit ? trial : p_sh;
        dq_nx = {dq[WIDTH-2:0], qbit};
        last  = cnt == CW'(1);
    end

    // next-state decode; START is only honoured in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = START ? ((DIVISOR == '0) ? ZERO : RUN) : IDLE;
            RUN:     state_nx = last ? IDLE : RUN;
            ZERO:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nx;
    end

    // datapath and result registers; outputs only change on completion
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            p           <= '0;
            dq          <= '0;
            dvs         <= '0;
            cnt         <= '0;
            DONE        <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        dq  <= DIVIDEND;
                        dvs <= DIVISOR;
                        p   <= '0;
                        cnt <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    p   <= p_nx;
                    dq  <= dq_nx;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        QUOTIENT    <= dq_nx;
                        REMAINDER   <= p_nx[WIDTH-1:0];
                        DIV_BY_ZERO <= 1'b0;
                        DONE        <= 1'b1;
                    end
                end
                ZERO: begin
                    QUOTIENT    <= '1;
                    REMAINDER   <= dq;
                    DIV_BY_ZERO <= 1'b1;
                    DONE        <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider with directed vectors and a random sweep
module tb_seq_divider;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] DIVIDEND = '0;
    logic [W-1:0] DIVISOR = '0;
    logic         BUSY, DONE, DIV_BY_ZERO;
    logic [W-1:0] QUOTIENT, REMAINDER;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    seq_divider #(.WIDTH(W)) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
        .BUSY(BUSY), .DONE(DONE), .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER),
        .DIV_BY_ZERO(DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // issue one request; caller sits #1 after an edge with the DUT idle (or in its DONE cycle)
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        START    = 1'b1;
        DIVIDEND = a;
        DIVISOR  = b;
        step();
        START = 1'b0;
        e.a   = a;
        e.b   = b;
        e.z   = (b == '0);
        e.q   = e.z ? '1 : a / b;
        e.r   = e.z ? a : a % b;
        e.cyc = cyc + (e.z ? 1 : W);
        sbq.push_back(e);
        check("busy_after_start", 64'(BUSY), 64'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!DONE && n < 100) begin
            step();
            n++;
        end
        if (!DONE) begin
            tests++;
            fails++;
            $display("FAIL wait_done: no DONE within 100 cycles");
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(a, b);
        wait_done();
        step();
    endtask

    // monitor: every DONE must match the oldest outstanding request
    always @(negedge CLK) begin
        if (RSTn && DONE) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: DONE at cycle %0d with empty scoreboard", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("quotient", 64'(QUOTIENT), 64'(e.q));
                check("remainder", 64'(REMAINDER), 64'(e.r));
                check("div_by_zero", 64'(DIV_BY_ZERO), 64'(e.z));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_low_at_done", 64'(BUSY), 64'(0));
                if (!e.z) begin
                    check("invariant_sum", 64'(QUOTIENT) * 64'(e.b) + 64'(REMAINDER), 64'(e.a));
                    check("invariant_rem_lt", 64'(REMAINDER < e.b), 64'(1));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        int n;
        repeat (3) step();
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_done", 64'(DONE), 64'(0));
        check("rst_q", 64'(QUOTIENT), 64'(0));
        check("rst_r", 64'(REMAINDER), 64'(0));
        check("rst_dbz", 64'(DIV_BY_ZERO), 64'(0));
        RSTn = 1'b1;
        step();

        run_op(100, 7);
        run_op(32'hFFFF_FFFF, 1);
        run_op(3, 10);
        run_op(5, 0);
        start_op(9, 3);
        repeat (5) step();
        check("held_q_midrun", 64'(QUOTIENT), 64'hFFFF_FFFF);
        check("held_dbz_midrun", 64'(DIV_BY_ZERO), 64'(1));
        wait_done();
        step();

        start_op(1000, 33);
        repeat (8) step();
        START    = 1'b1;
        DIVIDEND = 8;
        DIVISOR  = 2;
        step();
        START = 1'b0;
        check("busy_ignored_start", 64'(BUSY), 64'(1));
        wait_done();
        step();

        start_op(50, 5);
        repeat (13) step();
        RSTn = 1'b0;
        #1;
        check("midrst_busy", 64'(BUSY), 64'(0));
        check("midrst_done", 64'(DONE), 64'(0));
        check("midrst_q", 64'(QUOTIENT), 64'(0));
        check("midrst_r", 64'(REMAINDER), 64'(0));
        check("midrst_dbz", 64'(DIV_BY_ZERO), 64'(0));
        sbq.delete();
        step();
        RSTn = 1'b1;
        step();
        run_op(50, 5);

        start_op(77, 4);
        wait_done();
        start_op(77, 8);
        check("b2b_done_drops", 64'(DONE), 64'(0));
        wait_done();
        step();

        run_op(0, 32'hFFFF_FFFF);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_op(0, 0);
        run_op(32'h8000_0000, 3);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 10)
                0: rb = 0;
                1: ra = '1;
                2: rb = '1;
                3: rb = rb >> $urandom_range(31, 0);
                4: ra = 0;
                default: ;
            endcase
            start_op(ra, rb);
            wait_done();
        end
        step();

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
